// File: rtl/monitor_axi_pkg.sv
// rtl/monitor_axi_pkg.sv - shared AXI burst/response constants and FSM state types
package monitor_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

    // Beats wider than the bus, WRAP and the reserved encoding are all refused.
    function automatic logic burst_illegal(input logic [2:0] size, input logic [2:0] max_size,
                                           input logic [1:0] burst);
        return (size > max_size) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
    endfunction

endpackage

// File: rtl/monitor_sdp_ram.sv
// rtl/monitor_sdp_ram.sv - simple dual-port word RAM, byte-enabled write, registered read-first read
module monitor_sdp_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Both in one block so a same-cycle read of the written word sees the old value.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/monitor_axi_burst_slave.sv
// rtl/monitor_axi_burst_slave.sv - AXI4 INCR/FIXED burst responder over an internal word memory
module monitor_axi_burst_slave
    import monitor_axi_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_MEM_DEPTH        = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int LSB    = $clog2(C_S_AXI_DATA_WIDTH/8);
    localparam int MEM_AW = $clog2(C_MEM_DEPTH);
    localparam logic [2:0]        MAX_SIZE = 3'(LSB);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    wr_state_t         w_state;
    logic [ADDR_W-1:0] w_addr, w_next;
    logic [7:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err, w_lerr, w_beat, w_last_beat;

    rd_state_t         r_state;
    logic [ADDR_W-1:0] r_addr, r_next;
    logic [7:0]        r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_err;
    logic [C_S_AXI_DATA_WIDTH-1:0] ram_q;
    logic [MEM_AW-1:0] ram_raddr;

    assign w_next      = (w_burst == BURST_INCR) ? w_addr + (ADDR_ONE << w_size) : w_addr;
    assign r_next      = (r_burst == BURST_INCR) ? r_addr + (ADDR_ONE << r_size) : r_addr;
    assign w_beat      = S_AXI_WVALID && S_AXI_WREADY;
    assign w_last_beat = (w_cnt == w_len);

    // Look one word ahead on an accepted beat so consecutive beats stream at full rate.
    assign ram_raddr   = (S_AXI_RVALID && S_AXI_RREADY) ? r_next[LSB +: MEM_AW] : r_addr[LSB +: MEM_AW];
    assign S_AXI_RDATA = (S_AXI_RVALID && !r_err) ? ram_q : '0;

    monitor_sdp_ram #(.DATA_W(C_S_AXI_DATA_WIDTH), .DEPTH(C_MEM_DEPTH)) u_ram (
        .clk   (ACLK),
        .we    (w_beat && !w_err),
        .waddr (w_addr[LSB +: MEM_AW]),
        .wdata (S_AXI_WDATA),
        .wstrb (S_AXI_WSTRB),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            S_AXI_BRESP   <= RESP_OKAY;
            w_addr        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_err         <= 1'b0;
            w_lerr        <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    S_AXI_AWREADY <= 1'b1;
                    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        S_AXI_BID     <= S_AXI_AWID;
                        w_addr        <= S_AXI_AWADDR;
                        w_len         <= S_AXI_AWLEN;
                        w_size        <= S_AXI_AWSIZE;
                        w_burst       <= S_AXI_AWBURST;
                        w_cnt         <= '0;
                        w_err         <= burst_illegal(S_AXI_AWSIZE, MAX_SIZE, S_AXI_AWBURST);
                        w_lerr        <= 1'b0;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        // The beat count, not WLAST, ends the burst; WLAST only grades it.
                        if (w_last_beat) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= (w_err || w_lerr || !S_AXI_WLAST) ? RESP_SLVERR : RESP_OKAY;
                            w_state      <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt + 8'd1;
                            w_addr <= w_next;
                            if (S_AXI_WLAST) w_lerr <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RID     <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RID     <= S_AXI_ARID;
                        S_AXI_RRESP   <= burst_illegal(S_AXI_ARSIZE, MAX_SIZE, S_AXI_ARBURST)
                                         ? RESP_SLVERR : RESP_OKAY;
                        r_err         <= burst_illegal(S_AXI_ARSIZE, MAX_SIZE, S_AXI_ARBURST);
                        r_addr        <= S_AXI_ARADDR;
                        r_len         <= S_AXI_ARLEN;
                        r_size        <= S_AXI_ARSIZE;
                        r_burst       <= S_AXI_ARBURST;
                        r_cnt         <= '0;
                        r_state       <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    S_AXI_RVALID <= 1'b1;
                    S_AXI_RLAST  <= (r_len == 8'd0);
                    r_state      <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (S_AXI_RLAST) begin
                            S_AXI_RVALID  <= 1'b0;
                            S_AXI_RLAST   <= 1'b0;
                            S_AXI_ARREADY <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_cnt       <= r_cnt + 8'd1;
                            r_addr      <= r_next;
                            S_AXI_RLAST <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_monitor_axi_burst_slave.sv
// tb/tb_monitor_axi_burst_slave.sv - directed self-checking bench for monitor_axi_burst_slave
`timescale 1ns/1ps
module tb_monitor_axi_burst_slave;
    import monitor_axi_pkg::*;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic        ARESETN;
    logic [0:0]  S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
    logic [11:0] S_AXI_AWADDR, S_AXI_ARADDR;
    logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
    logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
    logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
    logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]  S_AXI_WSTRB;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] wbeat [256];
    logic [1:0]  b_resp;
    logic [0:0]  b_id, r_id;
    logic        b_ok;
    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    int          rd_cyc  [256];
    int          n_beats, lat, stall_bad;

    monitor_axi_burst_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    task automatic do_write(input logic [11:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] strb, input int early);
        int t;
        b_ok = 1'b0;
        S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWSIZE = size; S_AXI_AWBURST = burst;
        S_AXI_AWVALID = 1'b1;
        t = 0;
        while (!S_AXI_AWREADY && t < 50) begin @(negedge ACLK); t++; end
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            S_AXI_WDATA = wbeat[i]; S_AXI_WSTRB = strb;
            S_AXI_WLAST = (i == int'(len)) || (i == early);
            S_AXI_WVALID = 1'b1;
            t = 0;
            while (!S_AXI_WREADY && t < 50) begin @(negedge ACLK); t++; end
            @(negedge ACLK);
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; S_AXI_BREADY = 1'b1;
        t = 0;
        while (!S_AXI_BVALID && t < 50) begin @(negedge ACLK); t++; end
        b_ok = S_AXI_BVALID; b_resp = S_AXI_BRESP; b_id = S_AXI_BID;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
    endtask

    // mode 0: RREADY held high; mode 1: RREADY toggles every cycle.
    task automatic do_read(input logic [11:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode);
        int t, cyc;
        logic prev_stall;
        logic [31:0] prev_data;
        n_beats = 0; lat = -1; stall_bad = 0; prev_stall = 1'b0; prev_data = '0;
        S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARSIZE = size; S_AXI_ARBURST = burst;
        S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        t = 0;
        while (!S_AXI_ARREADY && t < 50) begin @(negedge ACLK); t++; end
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        cyc = 1;
        while (n_beats <= int'(len) && cyc < 700) begin
            S_AXI_RREADY = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
            if (prev_stall && S_AXI_RDATA !== prev_data) stall_bad++;
            if (S_AXI_RVALID && lat < 0) lat = cyc;
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (n_beats == 0) r_id = S_AXI_RID;
                rd_data[n_beats] = S_AXI_RDATA; rd_resp[n_beats] = S_AXI_RRESP;
                rd_last[n_beats] = S_AXI_RLAST; rd_cyc[n_beats] = cyc;
                n_beats++;
            end
            prev_stall = S_AXI_RVALID && !S_AXI_RREADY;
            prev_data  = S_AXI_RDATA;
            @(negedge ACLK);
            cyc++;
        end
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0; S_AXI_AWBURST = '0;
        S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARID = '0; S_AXI_ARADDR = '0;
        S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0; S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        n_cmp++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST,
             S_AXI_BRESP, S_AXI_RRESP, S_AXI_BID, S_AXI_RID} !== 12'h000) begin
            n_mis++; $display("FAIL reset_ctrl: got %h expected 000", {S_AXI_AWREADY, S_AXI_WREADY,
                S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST, S_AXI_BRESP, S_AXI_RRESP,
                S_AXI_BID, S_AXI_RID});
        end
        n_cmp++;
        if (S_AXI_RDATA !== 32'h0) begin
            n_mis++; $display("FAIL reset_rdata: got %h expected 00000000", S_AXI_RDATA);
        end
        ARESETN = 1'b1;
        @(negedge ACLK);
        n_cmp++;
        if ({S_AXI_AWREADY, S_AXI_ARREADY} !== 2'b11) begin
            n_mis++; $display("FAIL ready_after_reset: got %b expected 11", {S_AXI_AWREADY, S_AXI_ARREADY});
        end
    endtask

    task automatic test_incr_write_read();
        for (int i = 0; i < 8; i++) wbeat[i] = 32'(i + 1);
        S_AXI_AWID = 1'b1;
        do_write(12'h000, 8'd7, 3'd2, BURST_INCR, 4'hF, -1);
        n_cmp++;
        if ({b_ok, b_resp, b_id} !== {1'b1, RESP_OKAY, 1'b1}) begin
            n_mis++; $display("FAIL incr_bresp: got ok=%b resp=%b id=%b expected ok=1 resp=00 id=1", b_ok, b_resp, b_id);
        end
        S_AXI_ARID = 1'b1;
        do_read(12'h000, 8'd7, 3'd2, BURST_INCR, 0);
        n_cmp++;
        if (n_beats !== 8 || r_id !== 1'b1) begin
            n_mis++; $display("FAIL incr_beats: got beats=%0d rid=%b expected beats=8 rid=1", n_beats, r_id);
        end
        for (int i = 0; i < 8 && i < n_beats; i++) begin
            n_cmp++;
            if ({rd_data[i], rd_resp[i], rd_last[i]} !== {32'(i + 1), RESP_OKAY, (i == 7)}) begin
                n_mis++; $display("FAIL incr_beat%0d: got data=%h resp=%b last=%b expected data=%h resp=00 last=%b",
                                  i, rd_data[i], rd_resp[i], rd_last[i], 32'(i + 1), (i == 7));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_read(12'h000, 8'd7, 3'd2, BURST_INCR, 0);
        n_cmp++;
        if (lat !== 2) begin
            n_mis++; $display("FAIL ar_to_rvalid: got %0d expected 2", lat);
        end
        n_cmp++;
        if (n_beats !== 8 || rd_cyc[7] - rd_cyc[0] !== 7) begin
            n_mis++; $display("FAIL streaming: got beats=%0d span=%0d expected beats=8 span=7", n_beats, rd_cyc[7] - rd_cyc[0]);
        end
        do_read(12'h000, 8'd7, 3'd2, BURST_INCR, 1);
        n_cmp++;
        if (n_beats !== 8 || stall_bad !== 0) begin
            n_mis++; $display("FAIL stall: got beats=%0d unstable=%0d expected beats=8 unstable=0", n_beats, stall_bad);
        end
        for (int i = 0; i < 8 && i < n_beats; i++) begin
            n_cmp++;
            if (rd_data[i] !== 32'(i + 1)) begin
                n_mis++; $display("FAIL stall_beat%0d: got %h expected %h", i, rd_data[i], 32'(i + 1));
            end
        end
    endtask

    task automatic test_fixed();
        wbeat[0] = 32'hA; wbeat[1] = 32'hB; wbeat[2] = 32'hC; wbeat[3] = 32'hD;
        do_write(12'h010, 8'd3, 3'd2, BURST_FIXED, 4'hF, -1);
        n_cmp++;
        if ({b_ok, b_resp} !== {1'b1, RESP_OKAY}) begin
            n_mis++; $display("FAIL fixed_bresp: got ok=%b resp=%b expected ok=1 resp=00", b_ok, b_resp);
        end
        do_read(12'h00C, 8'd2, 3'd2, BURST_INCR, 0);
        n_cmp++;
        if ({rd_data[0], rd_data[1], rd_data[2]} !== {32'h4, 32'hD, 32'h6}) begin
            n_mis++; $display("FAIL fixed_data: got %h %h %h expected 00000004 0000000d 00000006",
                              rd_data[0], rd_data[1], rd_data[2]);
        end
    endtask

    task automatic test_wstrb();
        wbeat[0] = 32'h11223344; wbeat[1] = 32'h55667788;
        do_write(12'h040, 8'd1, 3'd2, BURST_INCR, 4'hF, -1);
        wbeat[0] = 32'hAABBCCDD;
        do_write(12'h040, 8'd0, 3'd2, BURST_INCR, 4'b0011, -1);
        do_read(12'h040, 8'd0, 3'd2, BURST_INCR, 0);
        n_cmp++;
        if (rd_data[0] !== 32'h1122CCDD) begin
            n_mis++; $display("FAIL wstrb: got %h expected 1122ccdd", rd_data[0]);
        end
    endtask

    task automatic test_errors();
        wbeat[0] = 32'hDEADBEEF; wbeat[1] = 32'hFEEDFACE;
        do_write(12'h040, 8'd1, 3'd3, BURST_INCR, 4'hF, -1);
        n_cmp++;
        if ({b_ok, b_resp} !== {1'b1, RESP_SLVERR}) begin
            n_mis++; $display("FAIL size_bresp: got ok=%b resp=%b expected ok=1 resp=10", b_ok, b_resp);
        end
        do_read(12'h040, 8'd1, 3'd2, BURST_INCR, 0);
        n_cmp++;
        if ({rd_data[0], rd_data[1]} !== {32'h1122CCDD, 32'h55667788}) begin
            n_mis++; $display("FAIL size_nowrite: got %h %h expected 1122ccdd 55667788", rd_data[0], rd_data[1]);
        end
        for (int i = 0; i < 4; i++) wbeat[i] = 32'h100 + 32'(i);
        do_write(12'h080, 8'd3, 3'd2, BURST_INCR, 4'hF, 1);
        n_cmp++;
        if ({b_ok, b_resp} !== {1'b1, RESP_SLVERR}) begin
            n_mis++; $display("FAIL wlast_bresp: got ok=%b resp=%b expected ok=1 resp=10", b_ok, b_resp);
        end
        do_read(12'h080, 8'd3, 3'd2, BURST_INCR, 0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== 32'h100 + 32'(i)) begin
                n_mis++; $display("FAIL wlast_beat%0d: got %h expected %h", i, rd_data[i], 32'h100 + 32'(i));
            end
        end
        do_read(12'h080, 8'd2, 3'd2, BURST_WRAP, 0);
        n_cmp++;
        if (n_beats !== 3) begin
            n_mis++; $display("FAIL wrap_read_beats: got %0d expected 3", n_beats);
        end
        for (int i = 0; i < 3 && i < n_beats; i++) begin
            n_cmp++;
            if ({rd_data[i], rd_resp[i], rd_last[i]} !== {32'h0, RESP_SLVERR, (i == 2)}) begin
                n_mis++; $display("FAIL wrap_read_beat%0d: got data=%h resp=%b last=%b expected data=0 resp=10 last=%b",
                                  i, rd_data[i], rd_resp[i], rd_last[i], (i == 2));
            end
        end
    endtask

    task automatic test_top_wrap();
        wbeat[0] = 32'hCAFE0001; wbeat[1] = 32'hCAFE0002;
        do_write(12'hFFC, 8'd1, 3'd2, BURST_INCR, 4'hF, -1);
        n_cmp++;
        if ({b_ok, b_resp} !== {1'b1, RESP_OKAY}) begin
            n_mis++; $display("FAIL top_bresp: got ok=%b resp=%b expected ok=1 resp=00", b_ok, b_resp);
        end
        do_read(12'hFFC, 8'd0, 3'd2, BURST_INCR, 0);
        n_cmp++;
        if (rd_data[0] !== 32'hCAFE0001) begin
            n_mis++; $display("FAIL top_word: got %h expected cafe0001", rd_data[0]);
        end
        do_read(12'h000, 8'd0, 3'd2, BURST_INCR, 0);
        n_cmp++;
        if (rd_data[0] !== 32'hCAFE0002) begin
            n_mis++; $display("FAIL wrapped_word0: got %h expected cafe0002", rd_data[0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int t;
        S_AXI_ARADDR = 12'h000; S_AXI_ARLEN = 8'd7; S_AXI_ARSIZE = 3'd2; S_AXI_ARBURST = BURST_INCR;
        S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        t = 0;
        while (!S_AXI_ARREADY && t < 50) begin @(negedge ACLK); t++; end
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        t = 0;
        while (!S_AXI_RVALID && t < 50) begin @(negedge ACLK); t++; end
        n_cmp++;
        if (S_AXI_RVALID !== 1'b1) begin
            n_mis++; $display("FAIL midburst_rvalid: got %b expected 1", S_AXI_RVALID);
        end
        #2 ARESETN = 1'b0;
        #1;
        n_cmp++;
        if ({S_AXI_RVALID, S_AXI_ARREADY, S_AXI_AWREADY} !== 3'b000) begin
            n_mis++; $display("FAIL async_reset: got %b expected 000", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_AWREADY});
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        n_cmp++;
        if (S_AXI_ARREADY !== 1'b1) begin
            n_mis++; $display("FAIL arready_after_reset: got %b expected 1", S_AXI_ARREADY);
        end
        do_read(12'h080, 8'd3, 3'd2, BURST_INCR, 0);
        n_cmp++;
        if (n_beats !== 4 || rd_data[0] !== 32'h100 || rd_data[3] !== 32'h103 || rd_last[3] !== 1'b1) begin
            n_mis++; $display("FAIL read_after_reset: got beats=%0d d0=%h d3=%h last=%b expected beats=4 d0=100 d3=103 last=1",
                              n_beats, rd_data[0], rd_data[3], rd_last[3]);
        end
    endtask

    initial begin
        test_reset();
        test_incr_write_read();
        test_back_to_back();
        test_fixed();
        test_wstrb();
        test_errors();
        test_top_wrap();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
